// File: rtl/branch_predictor.sv
// branch_predictor
//   Direct-mapped branch target buffer with a 2-bit saturating direction
//   counter per entry. Fetch looks up fetch_pc combinationally. The resolve
//   stage writes back outcomes, and the block flags mispredicts and supplies
//   the refetch PC. It also keeps saturating branch and mispredict counters.
//
// Ports
//   CLK, nRST        clock (rising edge), asynchronous active-low reset
//   fetch_pc         PC being fetched
//   pred_taken       lookup result: predicted taken
//   pred_npc         lookup result: predicted next PC
//   upd_en           one cycle per resolving control-flow instruction
//   upd_pc           PC of the resolving instruction
//   upd_taken        actual outcome
//   upd_target       actual target
//   upd_pred_taken   prediction carried with the instruction
//   upd_pred_npc     predicted next PC carried with the instruction
//   mispredict       resolution disagrees with the carried prediction
//   correct_pc       PC to refetch on a mispredict
//   clear            synchronous invalidate of all entries
//   branch_cnt       number of upd_en cycles (saturating)
//   mispred_cnt      number of mispredict cycles (saturating)
module branch_predictor #(
    parameter int unsigned ENTRIES   = 16,
    parameter logic [1:0]  CTR_INIT  = 2'b01,
    parameter logic [1:0]  ALLOC_CTR = 2'b10
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] fetch_pc,
    output logic        pred_taken,
    output logic [31:0] pred_npc,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_npc,
    output logic        mispredict,
    output logic [31:0] correct_pc,
    input  logic        clear,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);

    localparam int unsigned IW = $clog2(ENTRIES);
    localparam int unsigned TW = 32 - IW - 2;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TW-1:0]      tag_q    [ENTRIES];
    logic [TW-1:0]      tag_d    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [31:0]        target_d [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [1:0]         ctr_d    [ENTRIES];
    logic [31:0]        branch_cnt_q, branch_cnt_d;
    logic [31:0]        mispred_cnt_q, mispred_cnt_d;

    logic [IW-1:0] fidx, uidx;
    logic [TW-1:0] ftag, utag;
    logic          fhit, uhit;

    assign fidx = fetch_pc[IW+1:2];
    assign ftag = fetch_pc[31:IW+2];
    assign uidx = upd_pc[IW+1:2];
    assign utag = upd_pc[31:IW+2];

    // Lookup reads registered state only, so a same-cycle update to the
    // same index is not visible until the following cycle.
    assign fhit       = valid_q[fidx] && (tag_q[fidx] == ftag);
    assign pred_taken = fhit && ctr_q[fidx][1];
    assign pred_npc   = pred_taken ? target_q[fidx] : fetch_pc + 32'd4;

    assign uhit       = valid_q[uidx] && (tag_q[uidx] == utag);
    assign mispredict = upd_en && ((upd_taken != upd_pred_taken) ||
                                   (upd_taken && (upd_target != upd_pred_npc)));
    assign correct_pc = upd_taken ? upd_target : upd_pc + 32'd4;

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (clear) begin
            // Clear takes priority over a simultaneous update.
            valid_d = '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ctr_d[i] = CTR_INIT;
            end
        end else if (upd_en) begin
            if (uhit) begin
                if (upd_taken) begin
                    ctr_d[uidx]    = (ctr_q[uidx] == 2'd3) ? 2'd3 : ctr_q[uidx] + 2'd1;
                    target_d[uidx] = upd_target;
                end else begin
                    ctr_d[uidx] = (ctr_q[uidx] == 2'd0) ? 2'd0 : ctr_q[uidx] - 2'd1;
                end
            end else if (upd_taken) begin
                valid_d[uidx]  = 1'b1;
                tag_d[uidx]    = utag;
                target_d[uidx] = upd_target;
                ctr_d[uidx]    = ALLOC_CTR;
            end
        end
    end

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (upd_en && (branch_cnt_q != '1)) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
        end
        if (mispredict && (mispred_cnt_q != '1)) begin
            mispred_cnt_d = mispred_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q       <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_INIT;
            end
        end else begin
            valid_q       <= valid_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= tag_d[i];
                target_q[i] <= target_d[i];
                ctr_q[i]    <= ctr_d[i];
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

    logic        CLK;
    logic        nRST;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_npc;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_npc;
    logic        mispredict;
    logic [31:0] correct_pc;
    logic        clear;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    int total;
    int bad;

    branch_predictor #(
        .ENTRIES  (16),
        .CTR_INIT (2'b01),
        .ALLOC_CTR(2'b10)
    ) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .fetch_pc      (fetch_pc),
        .pred_taken    (pred_taken),
        .pred_npc      (pred_npc),
        .upd_en        (upd_en),
        .upd_pc        (upd_pc),
        .upd_taken     (upd_taken),
        .upd_target    (upd_target),
        .upd_pred_taken(upd_pred_taken),
        .upd_pred_npc  (upd_pred_npc),
        .mispredict    (mispredict),
        .correct_pc    (correct_pc),
        .clear         (clear),
        .branch_cnt    (branch_cnt),
        .mispred_cnt   (mispred_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drive one resolve cycle, check the same-cycle outputs, then clock it in.
    task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] pnpc,
                           input logic exp_mp, input logic [31:0] exp_cpc);
        upd_en         = 1'b1;
        upd_pc         = pc;
        upd_taken      = tk;
        upd_target     = tgt;
        upd_pred_taken = ptk;
        upd_pred_npc   = pnpc;
        #1;
        chk("mispredict", {31'd0, mispredict}, {31'd0, exp_mp});
        chk("correct_pc", correct_pc, exp_cpc);
        tick();
        upd_en = 1'b0;
        clear  = 1'b0;
        #1;
    endtask

    task automatic look(input string tag, input logic [31:0] pc,
                        input logic exp_tk, input logic [31:0] exp_npc);
        fetch_pc = pc;
        #1;
        chk({tag, ".taken"}, {31'd0, pred_taken}, {31'd0, exp_tk});
        chk({tag, ".npc"}, pred_npc, exp_npc);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        nRST = 1'b0; fetch_pc = 32'h40; upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        upd_target = '0; upd_pred_taken = 1'b0; upd_pred_npc = '0; clear = 1'b0;
        #3;
        // 1. reset state
        look("rst", 32'h40, 1'b0, 32'h44);
        chk("rst.branch_cnt", branch_cnt, 32'd0);
        chk("rst.mispred_cnt", mispred_cnt, 32'd0);
        chk("rst.mispredict_idle", {31'd0, mispredict}, 32'd0);
        #9 nRST = 1'b1;
        tick();

        // 2. allocation; same-cycle lookup must still miss
        fetch_pc = 32'h40;
        resolve(32'h40, 1'b1, 32'h100, 1'b0, 32'h44, 1'b1, 32'h100);
        look("alloc", 32'h40, 1'b1, 32'h100);
        chk("alloc.mispred_cnt", mispred_cnt, 32'd1);
        chk("alloc.branch_cnt", branch_cnt, 32'd1);

        // 3. hysteresis: ctr 2 -> 1 (not taken)
        resolve(32'h40, 1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h44);
        look("hyst1", 32'h40, 1'b0, 32'h44);
        // ctr 1 -> 2; same-cycle lookup sees pre-update (ctr 1)
        upd_en = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h100;
        upd_pred_taken = 1'b0; upd_pred_npc = 32'h44;
        look("bypass", 32'h40, 1'b0, 32'h44);
        resolve(32'h40, 1'b1, 32'h100, 1'b0, 32'h44, 1'b1, 32'h100);
        resolve(32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 32'h100); // -> 3
        resolve(32'h40, 1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h44);  // -> 2
        look("hyst2", 32'h40, 1'b1, 32'h100);
        // saturation at 3: 2 -> 3 -> 3 -> 2 remains taken
        resolve(32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 32'h100);
        resolve(32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 32'h100);
        resolve(32'h40, 1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h44);
        look("sat3", 32'h40, 1'b1, 32'h100);
        chk("hyst.branch_cnt", branch_cnt, 32'd8);
        chk("hyst.mispred_cnt", mispred_cnt, 32'd5);

        // 5. target change on a hit
        resolve(32'h40, 1'b1, 32'h180, 1'b1, 32'h100, 1'b1, 32'h180);
        look("retarget", 32'h40, 1'b1, 32'h180);

        // 4. alias at index 0
        resolve(32'h440, 1'b1, 32'h200, 1'b0, 32'h444, 1'b1, 32'h200);
        look("alias.old", 32'h40, 1'b0, 32'h44);
        look("alias.new", 32'h440, 1'b1, 32'h200);

        // miss, not taken: no allocation
        resolve(32'h84, 1'b0, 32'h300, 1'b0, 32'h88, 1'b0, 32'h88);
        look("nt_miss", 32'h84, 1'b0, 32'h88);
        chk("mid.branch_cnt", branch_cnt, 32'd11);
        chk("mid.mispred_cnt", mispred_cnt, 32'd7);

        // pred_npc wraps modulo 2^32
        look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

        // 6. clear wins over a simultaneous allocation, counters still count
        clear = 1'b1;
        resolve(32'h84, 1'b1, 32'h300, 1'b0, 32'h88, 1'b1, 32'h300);
        look("clr.alias", 32'h440, 1'b0, 32'h444);
        look("clr.dropped", 32'h84, 1'b0, 32'h88);
        chk("clr.branch_cnt", branch_cnt, 32'd12);
        chk("clr.mispred_cnt", mispred_cnt, 32'd8);
        // after clear, counter reloads CTR_INIT; reallocation gives ALLOC_CTR
        resolve(32'h40, 1'b1, 32'h100, 1'b0, 32'h44, 1'b1, 32'h100);
        look("realloc", 32'h40, 1'b1, 32'h100);

        // asynchronous reset mid-cycle
        #2 nRST = 1'b0;
        #1;
        chk("arst.branch_cnt", branch_cnt, 32'd0);
        chk("arst.mispred_cnt", mispred_cnt, 32'd0);
        look("arst", 32'h40, 1'b0, 32'h44);
        #3 nRST = 1'b1;
        tick();
        look("post_rst", 32'h40, 1'b0, 32'h44);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
